// File: rtl/id_ex_pipe_stage.sv
// Pipeline register between two stages with valid/ready flow control and a 2-entry skid.
// in_ready comes straight from a flop; flush squashes held entries; perf counters saturate.
module id_ex_pipe_stage #(
    parameter int unsigned       CTRL_W      = 18,
    parameter int unsigned       DATA_W      = 170,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Bit 0 = main entry valid, bit 1 = skid free; both outputs are bare flop bits.
    typedef enum logic [1:0] {
        StEmpty = 2'b10,
        StOne   = 2'b11,
        StTwo   = 2'b01
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

    logic accept;
    logic fire;

    assign out_valid = state_q[0];
    assign in_ready  = state_q[1];
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (flush) begin
            // Payload registers are left alone; only occupancy is squashed.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d  = StOne;
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end
                end
                StOne: begin
                    if (accept && fire) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (accept) begin
                        state_d  = StTwo;
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                    end else if (fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (fire) begin
                        state_d  = StOne;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Counters look at the pre-flush occupancy and are never cleared by flush.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        if (!out_valid && out_ready && bubble_cnt_q != CntMax) begin
            bubble_cnt_d = bubble_cnt_q + CntOne;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= StEmpty;
            m_ctrl_q     <= '0;
            m_data_q     <= '0;
            s_ctrl_q     <= '0;
            s_data_q     <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            m_ctrl_q     <= m_ctrl_d;
            m_data_q     <= m_data_d;
            s_ctrl_q     <= s_ctrl_d;
            s_data_q     <= s_data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_ctrl   = out_valid ? m_ctrl_q : BUBBLE_CTRL;
    assign out_data   = m_data_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage: directed scenarios plus a randomized run
// compared against a queue-based model of a 2-deep FIFO stage.
module tb_id_ex_pipe_stage;

    localparam int unsigned       CTRL_W = 18;
    localparam int unsigned       DATA_W = 170;
    localparam int unsigned       CNT_W  = 4;
    localparam logic [CTRL_W-1:0] BUBBLE = 18'h25A5A;
    localparam int                CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              Clk;
    logic              Rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    ent_t mq[$];
    int   stall_m;
    int   bubble_m;
    int   n_chk;
    int   n_err;

    id_ex_pipe_stage #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .BUBBLE_CTRL (BUBBLE),
        .CNT_W       (CNT_W)
    ) u_dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    task automatic model_clear();
        mq.delete();
        stall_m  = 0;
        bubble_m = 0;
    endtask

    task automatic check_model();
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        check_eq("out_valid", 192'(out_valid), 192'(mq.size() > 0));
        check_eq("in_ready", 192'(in_ready), 192'(mq.size() < 2));
        check_eq("out_ctrl", 192'(out_ctrl), 192'((mq.size() > 0) ? h.c : BUBBLE));
        if (mq.size() > 0) check_eq("out_data", 192'(out_data), 192'(h.d));
        check_eq("stall_cnt", 192'(stall_cnt), 192'(stall_m));
        check_eq("bubble_cnt", 192'(bubble_cnt), 192'(bubble_m));
    endtask

    // Called at a falling edge; drives one cycle, advances the model, re-checks at next fall.
    task automatic drive_cycle(input logic iv, input logic [CTRL_W-1:0] ic,
                               input logic [DATA_W-1:0] id, input logic ordy, input logic fl);
        bit acc;
        bit fir;
        ent_t e;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (mq.size() < 2);
        fir = (mq.size() > 0) && ordy;
        if (mq.size() > 0 && !ordy && stall_m < CNT_MAX) stall_m++;
        if (mq.size() == 0 && ordy && bubble_m < CNT_MAX) bubble_m++;
        if (fl) begin
            mq.delete();
        end else begin
            if (fir) void'(mq.pop_front());
            if (acc) begin
                e.c = ic;
                e.d = id;
                mq.push_back(e);
            end
        end
        @(posedge Clk);
        @(negedge Clk);
        check_model();
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        Rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge Clk);
        Rst = 1'b0;

        // Reset state
        check_eq("rst_in_ready", 192'(in_ready), 192'(1));
        check_eq("rst_out_valid", 192'(out_valid), 192'(0));
        check_eq("rst_out_ctrl", 192'(out_ctrl), 192'(BUBBLE));
        check_eq("rst_out_data", 192'(out_data), 192'(0));
        check_eq("rst_stall", 192'(stall_cnt), 192'(0));
        check_eq("rst_bubble", 192'(bubble_cnt), 192'(0));

        // Idle with out_ready=1: 10 bubbles, then saturation at 15
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("bubble_10", 192'(bubble_cnt), 192'(10));
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("bubble_sat", 192'(bubble_cnt), 192'(15));

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b1, CTRL_W'(i), DATA_W'(9 + i), 1'b1, 1'b0);
            check_eq("stream_valid", 192'(out_valid), 192'(1));
            check_eq("stream_ctrl", 192'(out_ctrl), 192'(i));
            check_eq("stream_data", 192'(out_data), 192'(9 + i));
            check_eq("stream_ready", 192'(in_ready), 192'(1));
        end
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("stream_stall0", 192'(stall_cnt), 192'(0));

        // Backpressure: entry 2 goes to the skid, 3 stall cycles, then drain in order
        drive_cycle(1'b1, 18'd1, 170'hA, 1'b1, 1'b0);
        drive_cycle(1'b1, 18'd2, 170'hB, 1'b0, 1'b0);
        check_eq("skid_ready", 192'(in_ready), 192'(0));
        drive_cycle(1'b1, 18'd3, 170'hC, 1'b0, 1'b0);
        drive_cycle(1'b1, 18'd3, 170'hC, 1'b0, 1'b0);
        check_eq("skid_head", 192'(out_ctrl), 192'(1));
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("drain_ctrl2", 192'(out_ctrl), 192'(2));
        check_eq("drain_ready", 192'(in_ready), 192'(1));
        drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("stall_3", 192'(stall_cnt), 192'(3));

        // Flush in TWO with a new input offered
        drive_cycle(1'b1, 18'h11, 170'h11, 1'b0, 1'b0);
        drive_cycle(1'b1, 18'h22, 170'h22, 1'b0, 1'b0);
        drive_cycle(1'b1, 18'h77, 170'h77, 1'b0, 1'b1);
        check_eq("flush_valid", 192'(out_valid), 192'(0));
        check_eq("flush_ctrl", 192'(out_ctrl), 192'(BUBBLE));
        check_eq("flush_ready", 192'(in_ready), 192'(1));
        // Flush in ONE with a real Accept that must be discarded
        drive_cycle(1'b1, 18'h33, 170'h33, 1'b0, 1'b0);
        drive_cycle(1'b1, 18'h44, 170'h44, 1'b1, 1'b1);
        check_eq("flush1_valid", 192'(out_valid), 192'(0));
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset while in TWO
        drive_cycle(1'b1, 18'h55, 170'h55, 1'b0, 1'b0);
        drive_cycle(1'b1, 18'h66, 170'h66, 1'b0, 1'b0);
        #2;
        Rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("arst_valid", 192'(out_valid), 192'(0));
        check_eq("arst_ready", 192'(in_ready), 192'(1));
        check_eq("arst_ctrl", 192'(out_ctrl), 192'(BUBBLE));
        check_eq("arst_stall", 192'(stall_cnt), 192'(0));
        check_eq("arst_bubble", 192'(bubble_cnt), 192'(0));
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 10000; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, CTRL_W'($urandom), rand_data(),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
